// File: rtl/uo_sched_pkg.sv
// Shared state encoding and constants for the output-pad scheduler.
package uo_sched_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned STROBE_BIT     = DEFAULT_DATA_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        STROBE  = ST_STROBE,
        RELEASE = ST_RELEASE
    } uo_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request searching upward
// from the index after last_grant, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uo_pad_scheduler.sv
// Shares the output pad bus among internal requesters: round-robin pick,
// data setup delay, then a 4-phase strobe/ack handshake with the host.
module uo_pad_scheduler
    import uo_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       ack_pad_i,
    input  logic                       err_clr_i,
    output logic [DATA_W:0]            uo_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       timeout_err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned SU_W  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(SETUP_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic            TO_EN   = (TIMEOUT != 0);

    logic [1:0]         state_q, state_d;
    logic               ack_meta, ack_s;
    logic [SU_W-1:0]    setup_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [DATA_W-1:0]  data_q;
    logic               strobe_q;
    logic               busy_q;
    logic [IDX_W-1:0]   grant_id_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic               err_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [DATA_W-1:0]  win_data;
    logic               accept_c;
    logic               setup_done_c;
    logic               to_expire_c;
    logic               to_set_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // Ready is held off during reset so nothing is accepted that would be lost.
    assign accept_c     = (state_q == ST_IDLE) && arb_any && !rst_i;
    assign req_ready_o  = accept_c ? arb_grant : '0;
    assign setup_done_c = (setup_cnt_q == SU_LAST);
    assign to_expire_c  = TO_EN && (to_cnt_q == TO_LAST);

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) win_data = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a seen ack takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        to_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (setup_done_c) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (ack_s) begin
                    state_d = ST_RELEASE;
                end else if (to_expire_c) begin
                    state_d  = ST_RELEASE;
                    to_set_c = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end else if (to_expire_c) begin
                    state_d  = ST_IDLE;
                    to_set_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous host ack pad.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ack_pad_i;
            ack_s    <= ack_meta;
        end
    end

    // Timeout count restarts on every state change, so each ack edge gets a full window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            setup_cnt_q <= (state_q == ST_SETUP) ? setup_cnt_q + SU_W'(1) : '0;
            to_cnt_q    <= (state_d != state_q) ? '0 : to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q       <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            if (accept_c) begin
                data_q       <= win_data;
                grant_id_q   <= arb_idx;
                last_grant_q <= arb_idx;
            end
            strobe_q <= (state_d == ST_STROBE);
            busy_q   <= (state_d != ST_IDLE);
            if (to_set_c)       err_q <= 1'b1;
            else if (err_clr_i) err_q <= 1'b0;
        end
    end

    assign uo_o          = {strobe_q, data_q};
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_id_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_uo_pad_scheduler.sv
// Bench for uo_pad_scheduler: directed table, multi-cycle corner sequences and
// a randomized run against an interval-based transfer model.
module tb_uo_pad_scheduler;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned SETUP_CYCLES = 4;
    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned IDX_W        = 2;
    localparam int          INF          = 1 << 30;

    logic                      clk;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      ack_pad_i;
    logic                      err_clr_i;
    logic [DATA_W:0]           uo_o;
    logic                      busy_o;
    logic [IDX_W-1:0]          grant_id_o;
    logic                      timeout_err_o;

    uo_pad_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .SETUP_CYCLES (SETUP_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .ack_pad_i     (ack_pad_i),
        .err_clr_i     (err_clr_i),
        .uo_o          (uo_o),
        .busy_o        (busy_o),
        .grant_id_o    (grant_id_o),
        .timeout_err_o (timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] ready;
        logic [DATA_W-1:0]  data;
    } vec_t;

    vec_t              tbl [10];
    logic [DATA_W-1:0] word [NUM_REQ];
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < NUM_REQ; k++) req_data_i[k*DATA_W +: DATA_W] = word[k];
    endtask

    task automatic do_reset(input int n);
        rst_i       = 1'b1;
        ack_pad_i   = 1'b0;
        err_clr_i   = 1'b0;
        req_valid_i = '0;
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        if (sel == 0) return uo_o[DATA_W];
        return busy_o;
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic val);
        int n = 0;
        while (sig(sel) !== val && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(sig(sel)), 32'(val));
    endtask

    // Host side of one handshake once a word has been accepted.
    task automatic finish_xfer(input string tag);
        wait_sig({tag, "_strobe_hi"}, 0, 1'b1);
        repeat (2) step();
        ack_pad_i = 1'b1;
        wait_sig({tag, "_strobe_lo"}, 0, 1'b0);
        step();
        ack_pad_i = 1'b0;
        wait_sig({tag, "_idle"}, 1, 1'b0);
    endtask

    task automatic run_vec(input int i);
        int n = 0;
        req_valid_i = tbl[i].valid;
        #1;
        while (req_ready_o === '0 && n < 100) begin
            step();
            n++;
        end
        check($sformatf("tbl%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].ready));
        step();
        check($sformatf("tbl%0d_pulse", i), 32'(req_ready_o), 32'h0);
        check($sformatf("tbl%0d_data", i), 32'(uo_o[DATA_W-1:0]), 32'(tbl[i].data));
        check($sformatf("tbl%0d_gid", i), 32'(grant_id_o), 32'(tbl[i].data[1:0]));
        finish_xfer($sformatf("tbl%0d", i));
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int lst);
        int k;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (lst + i) % NUM_REQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int                 last, a_c, s_c, rise_c, fall_c, idle_c, win, c, cur_gid;
        bit                 have_x, busy_e, strobe_e;
        logic [NUM_REQ-1:0] pend, exp_ready;
        logic [DATA_W-1:0]  cur_data;

        tbl[0] = '{4'b1111, 4'b0001, 16'h1000};
        tbl[1] = '{4'b1111, 4'b0010, 16'h1001};
        tbl[2] = '{4'b1111, 4'b0100, 16'h1002};
        tbl[3] = '{4'b1111, 4'b1000, 16'h1003};
        tbl[4] = '{4'b1111, 4'b0001, 16'h1000};
        tbl[5] = '{4'b0100, 4'b0100, 16'h1002};
        tbl[6] = '{4'b0011, 4'b0001, 16'h1000};
        tbl[7] = '{4'b0011, 4'b0010, 16'h1001};
        tbl[8] = '{4'b1001, 4'b1000, 16'h1003};
        tbl[9] = '{4'b1001, 4'b0001, 16'h1000};

        // Reset with every requester valid, then one timed transfer.
        rst_i = 1'b1; ack_pad_i = 1'b0; err_clr_i = 1'b0; req_valid_i = '1;
        for (int k = 0; k < NUM_REQ; k++) word[k] = DATA_W'(16'h1000 + k);
        word[0] = 16'hA5C3;
        drive_data();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_uo", 32'(uo_o), 32'h0);
            check("rst_ready", 32'(req_ready_o), 32'h0);
            check("rst_busy", 32'(busy_o), 32'h0);
            check("rst_gid", 32'(grant_id_o), 32'h0);
            check("rst_err", 32'(timeout_err_o), 32'h0);
        end
        rst_i = 1'b0;
        req_valid_i = 4'b0001;
        #1;
        check("st_ready", 32'(req_ready_o), 32'h1);
        for (int off = 1; off <= 18; off++) begin
            step();
            req_valid_i = '0;
            check($sformatf("st_data_%0d", off), 32'(uo_o[DATA_W-1:0]), 32'hA5C3);
            check($sformatf("st_strobe_%0d", off), 32'(uo_o[DATA_W]), 32'(off >= 5 && off < 11));
            check($sformatf("st_busy_%0d", off), 32'(busy_o), 32'(off < 17));
            ack_pad_i = (off >= 8 && off < 14);
        end

        // Round-robin order, skip and wrap.
        do_reset(2);
        for (int k = 0; k < NUM_REQ; k++) word[k] = DATA_W'(16'h1000 + k);
        drive_data();
        for (int i = 0; i < 10; i++) run_vec(i);
        req_valid_i = '0;

        // Strobe-phase timeout, sticky error, clear, then release-phase timeout
        // with a coincident clear (set must win).
        do_reset(2);
        word[0] = 16'h5A5A;
        word[1] = 16'hBEEF;
        drive_data();
        req_valid_i = 4'b0001;
        #1;
        check("to_ready", 32'(req_ready_o), 32'h1);
        for (int off = 1; off <= 24; off++) begin
            step();
            req_valid_i = '0;
            check($sformatf("to_strobe_%0d", off), 32'(uo_o[DATA_W]), 32'(off >= 5 && off < 21));
            check($sformatf("to_err_%0d", off), 32'(timeout_err_o), 32'(off >= 21));
            check($sformatf("to_busy_%0d", off), 32'(busy_o), 32'(off < 22));
        end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("to_err_clr", 32'(timeout_err_o), 32'h0);
        req_valid_i = 4'b0010;
        #1;
        check("rt_ready", 32'(req_ready_o), 32'h2);
        for (int off = 1; off <= 26; off++) begin
            step();
            req_valid_i = '0;
            check($sformatf("rt_data_%0d", off), 32'(uo_o[DATA_W-1:0]), 32'hBEEF);
            check($sformatf("rt_strobe_%0d", off), 32'(uo_o[DATA_W]), 32'(off >= 5 && off < 9));
            check($sformatf("rt_busy_%0d", off), 32'(busy_o), 32'(off < 25));
            check($sformatf("rt_err_%0d", off), 32'(timeout_err_o), 32'(off >= 25));
            ack_pad_i = (off >= 6);
            err_clr_i = (off == 24);
        end
        ack_pad_i = 1'b0;
        err_clr_i = 1'b0;

        // Reset while strobe is high: word dropped, requester 0 first afterwards.
        do_reset(2);
        word[0] = 16'h0F0F;
        word[1] = 16'h1234;
        drive_data();
        req_valid_i = 4'b0010;
        #1;
        check("rm_ready1", 32'(req_ready_o), 32'h2);
        step();
        req_valid_i = 4'b0011;
        repeat (4) step();
        check("rm_strobe", 32'(uo_o[DATA_W]), 32'h1);
        rst_i = 1'b1;
        step();
        check("rm_uo", 32'(uo_o), 32'h0);
        check("rm_busy", 32'(busy_o), 32'h0);
        check("rm_gid", 32'(grant_id_o), 32'h0);
        check("rm_ready_rst", 32'(req_ready_o), 32'h0);
        step();
        rst_i = 1'b0;
        #1;
        check("rm_first", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = 4'b0010;
        check("rm_data0", 32'(uo_o[DATA_W-1:0]), 32'h0F0F);
        finish_xfer("rm0");
        #1;
        check("rm_next", 32'(req_ready_o), 32'h2);
        step();
        req_valid_i = '0;
        check("rm_data1", 32'(uo_o[DATA_W-1:0]), 32'h1234);
        finish_xfer("rm1");

        // Randomized traffic against an interval model of each transfer.
        do_reset(2);
        last = NUM_REQ - 1;
        pend = '0;
        have_x = 1'b0;
        a_c = 0; s_c = INF; rise_c = INF; fall_c = INF; idle_c = INF;
        cur_data = '0;
        cur_gid  = 0;
        for (int it = 0; it < 3000; it++) begin
            c        = cyc;
            busy_e   = have_x && c >= a_c + 1 && c < idle_c;
            strobe_e = have_x && c >= s_c && c < rise_c + 3;
            check("rnd_busy", 32'(busy_o), 32'(busy_e));
            check("rnd_strobe", 32'(uo_o[DATA_W]), 32'(strobe_e));
            check("rnd_data", 32'(uo_o[DATA_W-1:0]), 32'(cur_data));
            check("rnd_gid", 32'(grant_id_o), 32'(cur_gid));
            check("rnd_err", 32'(timeout_err_o), 32'h0);

            if (strobe_e && rise_c == INF) rise_c = c + int'($urandom_range(0, 6));
            if (have_x && rise_c != INF && c >= rise_c + 3 && fall_c == INF) begin
                fall_c = c + int'($urandom_range(0, 6));
                idle_c = fall_c + 3;
            end
            ack_pad_i = (c >= rise_c && c < fall_c);

            for (int k = 0; k < NUM_REQ; k++) begin
                if (pend[k]) begin
                    if ($urandom_range(0, 31) == 0) pend[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    word[k] = DATA_W'($urandom);
                end
            end
            req_valid_i = pend;
            drive_data();
            #1;
            exp_ready = '0;
            win = -1;
            if (!busy_e && pend != '0) begin
                win       = rr_pick(pend, last);
                exp_ready = NUM_REQ'(1) << win;
            end
            check("rnd_ready", 32'(req_ready_o), 32'(exp_ready));
            if (win >= 0) begin
                have_x   = 1'b1;
                a_c      = c;
                s_c      = c + 1 + int'(SETUP_CYCLES);
                rise_c   = INF;
                fall_c   = INF;
                idle_c   = INF;
                cur_data = word[win];
                cur_gid  = win;
                last     = win;
                pend[win] = 1'b0;
            end
            step();
        end
        ack_pad_i   = 1'b0;
        req_valid_i = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
